// File: rtl/button_debounce_sync.sv
// Multi-channel push-button front end: 2-flop synchroniser, per-channel debounce,
// one-cycle press/release pulses and optional auto-repeat of the press pulse.
module button_debounce_sync #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 32,
  parameter int unsigned REPEAT_RATE     = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Bi,
  input  logic [N-1:0] RepeatEn,
  output logic [N-1:0] Bo,
  output logic [N-1:0] Br,
  output logic [N-1:0] Level
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } state_e;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          bo_q;
    logic          br_q;
    logic [DW-1:0] deb_q;
    logic [RW-1:0] rep_q;
    state_e        state_q;
    logic          deb_done;
    logic [RW-1:0] rep_last;

    // Level flips on this edge: the synchronised value has disagreed long enough.
    assign deb_done = (s2_q != level_q) && (deb_q == DEB_LAST);
    assign rep_last = (state_q == PRESSED) ? DELAY_LAST : RATE_LAST;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        bo_q    <= 1'b0;
        br_q    <= 1'b0;
        deb_q   <= '0;
        rep_q   <= '0;
        state_q <= RELEASED;
      end else begin
        s1_q <= Bi[g];
        s2_q <= s1_q;

        if (s2_q == level_q) begin
          deb_q <= '0;
        end else if (deb_done) begin
          deb_q   <= '0;
          level_q <= ~level_q;
        end else begin
          deb_q <= deb_q + DW'(1);
        end

        bo_q <= 1'b0;
        br_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (deb_done) begin
              state_q <= PRESSED;
              bo_q    <= 1'b1;
              rep_q   <= '0;
            end
          end
          PRESSED, REPEATING: begin
            // Release takes priority over a repeat pulse due on the same edge.
            if (deb_done) begin
              state_q <= RELEASED;
              br_q    <= 1'b1;
              rep_q   <= '0;
            end else if (!RepeatEn[g]) begin
              state_q <= PRESSED;
              rep_q   <= '0;
            end else if (rep_q == rep_last) begin
              state_q <= REPEATING;
              bo_q    <= 1'b1;
              rep_q   <= '0;
            end else begin
              rep_q <= rep_q + RW'(1);
            end
          end
          default: begin
            state_q <= RELEASED;
            rep_q   <= '0;
          end
        endcase
      end
    end

    assign Bo[g]    = bo_q;
    assign Br[g]    = br_q;
    assign Level[g] = level_q;
  end

endmodule

// File: tb/tb_button_debounce_sync.sv
// Bench for button_debounce_sync: window/timestamp reference model checked every
// cycle, plus hand-computed pins on the key latencies.
module tb_button_debounce_sync;

  localparam int unsigned N  = 4;
  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] Bi;
  logic [N-1:0] RepeatEn;
  logic [N-1:0] Bo;
  logic [N-1:0] Br;
  logic [N-1:0] Level;

  int total = 0;
  int bad   = 0;

  button_debounce_sync #(
    .N(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Bi(Bi), .RepeatEn(RepeatEn),
    .Bo(Bo), .Br(Br), .Level(Level)
  );

  always #5 Clk = ~Clk;

  // Reference model: the synchroniser is a two-deep delay, a level is accepted once
  // the last DC synchronised samples all disagree with it, and repeat pulses are
  // scheduled from the timestamp of the last press / repeat / disabled edge.
  logic [N-1:0]  p1, p2;
  logic [DC-1:0] win [N];
  logic [N-1:0]  exp_lvl, exp_bo, exp_br;
  int            anchor [N];
  bit            first  [N];
  int            t = 0;
  bit            mdl_valid = 1'b0;

  always @(posedge Clk) begin
    logic [N-1:0] seen;
    logic [DC-1:0] want;
    t++;
    mdl_valid = 1'b1;
    if (Reset) begin
      p1 = '0; p2 = '0;
      exp_lvl = '0; exp_bo = '0; exp_br = '0;
      for (int i = 0; i < N; i++) begin
        win[i] = '0; anchor[i] = 0; first[i] = 1'b1;
      end
    end else begin
      seen = p2; p2 = p1; p1 = Bi;
      exp_bo = '0; exp_br = '0;
      for (int i = 0; i < N; i++) begin
        win[i] = {win[i][DC-2:0], seen[i]};
        want   = exp_lvl[i] ? '0 : '1;
        if (win[i] == want) begin
          if (!exp_lvl[i]) begin
            exp_bo[i] = 1'b1; anchor[i] = t; first[i] = 1'b1;
          end else begin
            exp_br[i] = 1'b1;
          end
          exp_lvl[i] = ~exp_lvl[i];
        end else if (exp_lvl[i]) begin
          if (!RepeatEn[i]) begin
            anchor[i] = t; first[i] = 1'b1;
          end else if (t - anchor[i] == (first[i] ? int'(RD) : int'(RR))) begin
            exp_bo[i] = 1'b1; anchor[i] = t; first[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, t, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (mdl_valid) begin
      chk("level", Level, exp_lvl);
      chk("bo", Bo, exp_bo);
      chk("br", Br, exp_br);
      chk("bo_br_overlap", Bo & Br, '0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pin(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL pin_%s at cycle %0d: got %b want %b", name, t, got, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Bi = '0; RepeatEn = '0;
    step(2);
    pin("rst_level", |Level, 1'b0);
    pin("rst_bo", |Bo, 1'b0);
    pin("rst_br", |Br, 1'b0);
    Reset = 1'b0;
    step(2);

    // Clean press on channel 0, first high sample at edge t0.
    Bi[0] = 1'b1;
    step(5);
    pin("press_early", Level[0], 1'b0);
    step(1);
    pin("press_level", Level[0], 1'b1);
    pin("press_bo", Bo[0], 1'b1);
    step(1);
    pin("press_bo_width", Bo[0], 1'b0);
    step(33);
    Bi[0] = 1'b0;
    step(5);
    pin("rel_early", Br[0], 1'b0);
    step(1);
    pin("rel_br", Br[0], 1'b1);
    pin("rel_level", Level[0], 1'b0);
    step(1);
    pin("rel_br_width", Br[0], 1'b0);
    step(3);

    // Bounce on channel 1: no high run reaches DC samples until the final one.
    Bi[1] = 1'b1; step(2);
    Bi[1] = 1'b0; step(1);
    Bi[1] = 1'b1; step(2);
    Bi[1] = 1'b1; step(1);
    Bi[1] = 1'b0; step(2);
    pin("bounce_quiet", Level[1], 1'b0);
    Bi[1] = 1'b1;
    step(5);
    pin("bounce_early", Level[1], 1'b0);
    step(1);
    pin("bounce_bo", Bo[1], 1'b1);
    step(4);
    Bi[1] = 1'b0;
    step(8);

    // Auto-repeat on channel 2; P is the edge raising the press pulse.
    RepeatEn[2] = 1'b1; Bi[2] = 1'b1;
    step(6);
    pin("rep_press", Bo[2], 1'b1);
    step(9);
    pin("rep_before_first", Bo[2], 1'b0);
    step(1);
    pin("rep_p10", Bo[2], 1'b1);
    step(3);
    pin("rep_p13", Bo[2], 1'b1);
    RepeatEn[2] = 1'b0;
    step(3);
    pin("rep_disabled_p16", Bo[2], 1'b0);
    RepeatEn[2] = 1'b1;
    step(9);
    pin("rep_reen_early", Bo[2], 1'b0);
    step(1);
    pin("rep_reen_p26", Bo[2], 1'b1);
    // Level falls at P+32, exactly when the repeat after P+29 is due.
    Bi[2] = 1'b0;
    step(3);
    pin("rep_p29", Bo[2], 1'b1);
    step(3);
    pin("collide_br", Br[2], 1'b1);
    pin("collide_bo", Bo[2], 1'b0);
    RepeatEn[2] = 1'b0;
    step(4);

    // Reset while channel 3 is held and accepted.
    Bi[3] = 1'b1;
    step(6);
    pin("rst3_level", Level[3], 1'b1);
    step(3);
    Reset = 1'b1;
    step(1);
    pin("mid_rst_level", |Level, 1'b0);
    pin("mid_rst_bo", |Bo, 1'b0);
    pin("mid_rst_br", |Br, 1'b0);
    Reset = 1'b0;
    step(5);
    pin("post_rst_early", Level[3], 1'b0);
    step(1);
    pin("post_rst_bo", Bo[3], 1'b1);
    step(3);
    Bi[3] = 1'b0;
    step(8);

    // All channels together, staggered releases.
    Bi = '1;
    step(6);
    pin("multi_bo", &Bo, 1'b1);
    step(4);
    Bi[0] = 1'b0; step(2);
    Bi[1] = 1'b0; step(2);
    Bi[2] = 1'b0; step(2);
    Bi[3] = 1'b0;
    step(10);
    pin("final_level", |Level, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
